// File: rtl/bcd_7seg_scan_driver_if.sv
// Display-side bundle for the scanned 7-segment driver.
// master drives load/bcd_in; slave (the driver) returns seg/an/frame_done.
interface bcd_7seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output load, bcd_in,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, bcd_in,
    output seg, an, frame_done
  );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed common-anode BCD 7-segment scan driver.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 1000
) (
  input logic clk,
  input logic rst,
  bcd_7seg_scan_driver_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    wrap;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    fd_q;

  logic                    cnt_last;
  logic                    idx_last;
  logic [3:0]              nib;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS:0]     zhi;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign cnt_last = (cnt == CNT_LAST);
  assign idx_last = (idx == IDX_LAST);

  // zhi[i]: digit i and every more-significant digit are zero
  always_comb begin
    zhi = '0;
    zhi[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zhi[i] = zhi[i+1] && (shadow[4*i +: 4] == 4'd0);
  end

  always_comb begin
    nib    = 4'd0;
    an_sel = '1;
    blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = shadow[4*i +: 4];
        an_sel[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (i >= 1)
          blank = zhi[i];
`endif
      end
    end
  end

  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = '1;
    if (cnt != '0) begin
      an_nxt  = an_sel;
      seg_nxt = blank ? SEG_OFF : dec(nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= '1;
      fd_q   <= 1'b0;
    end else begin
      if (bus.load)
        shadow <= bus.bcd_in;
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // delayed one cycle so the pulse lands on digit 0's dead slot output
      wrap  <= cnt_last && idx_last;
      fd_q  <= wrap;
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

  logic unused;
  assign unused = zhi[0];
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed scoreboard bench for bcd_7seg_scan_driver.
// Four digits, four clocks per digit slot.
module tb_bcd_7seg_scan_driver;
  localparam int ND = 4;
  localparam int CP = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t        q[$];
  logic [15:0] m_sh;
  int          m_cnt;
  int          m_idx;
  bit          m_wrap;
  int          since;
  bit          have_prev;
  int          pulses;

  bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  bcd_7seg_scan_driver #(
    .NUM_DIGITS    (ND),
    .CLKS_PER_DIGIT(CP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'h7F, 7'h7F,
          7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return t[v];
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input int d,
                                         input logic [15:0] sh);
    logic [6:0] s;
    if (c == 0) return 7'h7F;
    s = dec(sh[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (d >= 1 && (sh >> (4*d)) == 16'd0) s = 7'h7F;
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_sh      = '0;
    m_cnt     = 0;
    m_idx     = 0;
    m_wrap    = 0;
    have_prev = 0;
    since     = 0;
  endtask

  task automatic tick();
    exp_t e;
    exp_t p;
    @(posedge clk);
    if (rst) begin
      e = '{seg: 7'h7F, an: 4'hF, fd: 1'b0};
      reset_model();
    end else begin
      e.seg  = exp_seg(m_cnt, m_idx, m_sh);
      e.an   = (m_cnt == 0) ? 4'hF : ~(4'(1) << m_idx);
      e.fd   = m_wrap;
      m_wrap = (m_cnt == CP-1) && (m_idx == ND-1);
      if (bus.load) m_sh = bus.bcd_in;
      if (m_cnt == CP-1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
    end
    q.push_back(e);
    #1;
    p = q.pop_front();
    chk("seg", 32'(bus.seg), 32'(p.seg));
    chk("an", 32'(bus.an), 32'(p.an));
    chk("frame_done", 32'(bus.frame_done), 32'(p.fd));
    since++;
    if (bus.frame_done === 1'b1) begin
      if (have_prev) chk("fd_period", since, ND*CP);
      have_prev = 1;
      since     = 0;
      pulses++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    tick();
    bus.load   = 1'b0;
  endtask

  initial begin
    int guard;
    clk        = 0;
    rst        = 1;
    errors     = 0;
    checks     = 0;
    pulses     = 0;
    bus.load   = 0;
    bus.bcd_in = '0;
    reset_model();
    run(2);
    rst = 0;

    load_val(16'h1234);
    run(40);

    // free run three frames; pulses are spaced by the period check
    pulses = 0;
    run(3*ND*CP);
    chk("fd_count_3frames", pulses, 3);

    // asynchronous reset in the middle of a slot
    run(6);
    #2;
    rst = 1;
    #1;
    chk("async_rst_seg", 32'(bus.seg), 32'h7F);
    chk("async_rst_an", 32'(bus.an), 32'hF);
    chk("async_rst_fd", 32'(bus.frame_done), 0);
    reset_model();
    run(2);
    rst = 0;
    tick();
    chk("post_rst_dead_an", 32'(bus.an), 32'hF);
    tick();
    chk("post_rst_lit_an", 32'(bus.an), 32'hE);
    chk("post_rst_lit_seg", 32'(bus.seg), 32'(7'b0000001));
    run(20);

    load_val(16'h00A9);
    run(2*ND*CP);

    load_val(16'h0070);
    run(ND*CP + 2);
    load_val(16'h0000);
    run(ND*CP + 2);

    // mid-slot reload shows in the same digit-2 slot
    load_val(16'h5555);
    guard = 0;
    while (!(m_idx == 2 && m_cnt == 2) && guard < 100) begin
      tick();
      guard++;
    end
    chk("digit2_wait_bound", guard < 100, 1);
    load_val(16'h8888);
    tick();
    chk("reload_same_slot_an", 32'(bus.an), 32'(4'b1011));
    chk("reload_same_slot_seg", 32'(bus.seg), 32'(7'b0000000));
    run(ND*CP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
